// File: rtl/leds_seq.sv
// LED pattern sequencer: static, blink, chase and binary count modes with a step prescaler.
// Optional brightness PWM gating is enabled by defining LEDS_SEQ_PWM_EN.
module leds_seq #(
  parameter int N_LEDS   = 5,
  parameter int PRESCALE = 12000000,
  parameter int PWM_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [N_LEDS-1:0] pattern,
  input  logic              load,
  input  logic              pause,
`ifdef LEDS_SEQ_PWM_EN
  input  logic [PWM_BITS-1:0] brightness,
`endif
  output logic [N_LEDS-1:0] leds,
  output logic              step
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [N_LEDS-1:0] LED_ONE  = N_LEDS'(1);

  if (N_LEDS < 1 || N_LEDS > 32) begin : g_bad_n_leds
    $error("leds_seq: N_LEDS must be in 1..32");
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("leds_seq: PRESCALE must be >= 2");
  end

  typedef enum logic [1:0] {
    M_STATIC = 2'd0,
    M_BLINK  = 2'd1,
    M_CHASE  = 2'd2,
    M_COUNT  = 2'd3
  } mode_t;

  mode_t             mode_q;
  logic [CW-1:0]     cnt;
  logic [N_LEDS-1:0] pat_reg;
  logic [N_LEDS-1:0] shifter;
  logic [N_LEDS-1:0] counter;
  logic              phase;
  logic              tick;
  logic [N_LEDS-1:0] decode;

  // Index-based rotate so that N_LEDS=1 degenerates to a no-op without special slicing.
  function automatic logic [N_LEDS-1:0] rotl1(input logic [N_LEDS-1:0] v);
    logic [N_LEDS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      r[(i + 1) % N_LEDS] = v[i];
    end
    return r;
  endfunction

  assign tick = (cnt == CNT_LAST) && !pause;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= M_STATIC;
      cnt     <= '0;
      pat_reg <= '0;
      shifter <= '0;
      counter <= '0;
      phase   <= 1'b1;
      step    <= 1'b0;
    end else begin
      step <= 1'b0;
      if (load) pat_reg <= pattern;
      if (mode_t'(mode) != mode_q) begin
        mode_q  <= mode_t'(mode);
        cnt     <= '0;
        shifter <= load ? pattern : pat_reg;
        counter <= '0;
        phase   <= 1'b1;
      end else begin
        if (!pause) begin
          if (tick) begin
            cnt  <= '0;
            step <= 1'b1;
            case (mode_q)
              M_BLINK: phase   <= ~phase;
              M_CHASE: shifter <= rotl1(shifter);
              M_COUNT: counter <= counter + LED_ONE;
              default: ;
            endcase
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        // Placed last so a load on a tick edge overrides the rotate.
        if (load) shifter <= pattern;
      end
    end
  end

  always_comb begin
    decode = '0;
    case (mode_q)
      M_STATIC: decode = pat_reg;
      M_BLINK:  decode = phase ? pat_reg : '0;
      M_CHASE:  decode = shifter;
      M_COUNT:  decode = counter;
      default:  decode = '0;
    endcase
  end

`ifdef LEDS_SEQ_PWM_EN
  localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                gate;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + PWM_ONE;
  end

  assign gate = (brightness == '1) || (pwm_cnt < brightness);
  assign leds = decode & {N_LEDS{gate}};
`else
  assign leds = decode;
`endif

endmodule
